tdc_top: RTL and testbench

Time-to-digital converter front end. A `start` rising edge arms a measurement and pulses `temp_reset` to clear the external sensor. While running, an 8-bit counter counts clock cycles until the STOP_EDGES-th rising edge of `data_in`. It then presents the result on `count_out` and raises `ready`. The block sits between the sensor/oscillator output (`data_in`) and the digital readout logic.

---
 rtl/tdc_top.sv | 153 +++++++++++++++
 tb/tb_tdc_top.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/tdc_top.sv
// ---------------------------------------------------------------------------
// tdc_top -- time-to-digital converter front end
//
// A rising edge on `start` arms a measurement. The arm cycle pulses
// `temp_reset` to clear the external sensor. The block then counts clock
// cycles until the STOP_EDGES-th rising edge of `data_in`, or until the
// count saturates at 255. The result is held on `count_out` with `ready`
// high until the next arm.
//
// Optional feature macro: TDC_SYNC_EN
//   Defined:     `start` and `data_in` each pass through a two-flop
//                synchronizer before edge detection. Both paths add +2 cycles
//                of latency, so count_out values are unchanged.
//   Not defined: the inputs must already be synchronous to clk.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   measurement request, rising-edge sensitive
//   data_in     in   event input to be timed, rising-edge sensitive
//   count_out   out  [7:0] measured cycle count, held until the next arm
//   ready       out  high while a valid result is held
//   running     out  high while counting
//   temp_reset  out  one-cycle sensor clear pulse in the arm cycle
// ---------------------------------------------------------------------------
module tdc_top #(
    parameter int STOP_EDGES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       data_in,
    output logic [7:0] count_out,
    output logic       ready,
    output logic       running,
    output logic       temp_reset
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] STOP_N = 4'(STOP_EDGES);

    logic start_s, data_s;

`ifdef TDC_SYNC_EN
    logic [1:0] start_sync_q, data_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_sync_q <= 2'b00;
            data_sync_q  <= 2'b00;
        end else begin
            start_sync_q <= {start_sync_q[0], start};
            data_sync_q  <= {data_sync_q[0], data_in};
        end
    end

    assign start_s = start_sync_q[1];
    assign data_s  = data_sync_q[1];
`else
    assign start_s = start;
    assign data_s  = data_in;
`endif

    // Edge-detect history. It is reloaded with the current sample every
    // cycle, including the arm cycle. A data_in level that is already high
    // at arm time therefore does not produce an edge in the first RUN cycle.
    logic start_hist_q, data_hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_hist_q <= 1'b0;
            data_hist_q  <= 1'b0;
        end else begin
            start_hist_q <= start_s;
            data_hist_q  <= data_s;
        end
    end

    logic start_rise, data_rise;
    assign start_rise = start_s & ~start_hist_q;
    assign data_rise  = data_s  & ~data_hist_q;

    logic [1:0] state_q, state_d;
    logic [7:0] cyc_q, cyc_d;
    logic [3:0] edge_q, edge_d;
    logic [7:0] cnt_out_q, cnt_out_d;

    logic [7:0] cyc_inc;
    logic [3:0] edge_inc;
    assign cyc_inc  = (cyc_q == 8'hFF) ? cyc_q : cyc_q + 8'd1;
    assign edge_inc = edge_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        edge_d    = edge_q;
        cnt_out_d = cnt_out_q;
        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d   = S_ARM;
                    cnt_out_d = 8'd0;
                end
            end
            S_ARM: begin
                cyc_d   = 8'd0;
                edge_d  = 4'd0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cyc_d = cyc_inc;
                if (data_rise) edge_d = edge_inc;
                // The terminating cycle is still counted, so the result is
                // the post-increment value. Saturation ends the measurement
                // as an overflow.
                if ((data_rise && edge_inc == STOP_N) || cyc_inc == 8'hFF) begin
                    state_d   = S_DONE;
                    cnt_out_d = cyc_inc;
                end
            end
            default: begin  // S_DONE
                if (start_rise) begin
                    state_d   = S_ARM;
                    cnt_out_d = 8'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cyc_q     <= 8'd0;
            edge_q    <= 4'd0;
            cnt_out_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            edge_q    <= edge_d;
            cnt_out_q <= cnt_out_d;
        end
    end

    assign count_out  = cnt_out_q;
    assign ready      = (state_q == S_DONE);
    assign running    = (state_q == S_RUN);
    assign temp_reset = (state_q == S_ARM);

endmodule

// File: tb/tb_tdc_top.sv
module tb_tdc_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       data_in;
    logic [7:0] count_out;
    logic       ready, running, temp_reset;

    int checks = 0;
    int errors = 0;

    tdc_top #(.STOP_EDGES(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .count_out  (count_out),
        .ready      (ready),
        .running    (running),
        .temp_reset (temp_reset)
    );

    always #5 clk = ~clk;

    // Step to the next cycle. Outputs are sampled 1 time unit after the
    // rising edge, and inputs for the new cycle are driven afterwards.
`ifdef TDC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int cyc,
                       input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s C%0d: got tr/run/rdy/cnt=%b/%b/%b/%0d want %b/%b/%b/%0d",
                     name, cyc, act[10], act[9], act[8], act[7:0],
                     exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    // Each vector describes one measurement. e0..e5 are the cycles (relative
    // to C0) in which data_in is high for one cycle, and 0 means unused.
    // arm_hi holds data_in high through C0..C1. run_start pulses start in
    // that cycle (0 means none). hold keeps start high for the whole vector.
    typedef struct {
        int    e0, e1, e2, e3, e4, e5;
        bit    arm_hi;
        int    run_start;
        bit    hold;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int a, input int b, input int c, input int d,
                       input int f, input int g, input bit arm_hi,
                       input int rs, input bit hold, input string nm);
        vec_t v;
        v.e0 = a; v.e1 = b; v.e2 = c; v.e3 = d; v.e4 = f; v.e5 = g;
        v.arm_hi = arm_hi; v.run_start = rs; v.hold = hold; v.name = nm;
        vecs.push_back(v);
    endtask

    // Cycle indices below are relative to the edge-detect stage. With the
    // synchronizer enabled, outputs are compared LAT cycles later.
    task automatic run_vec(input vec_t v);
        int ed[6];
        int x, n, kmax, last;
        logic [10:0] exp;
        ed = '{v.e0, v.e1, v.e2, v.e3, v.e4, v.e5};
        // Reference model: rises in RUN (C2 onwards) are counted, and the
        // third one terminates. With no terminating rise, RUN lasts 255
        // cycles (C2..C256).
        x = 256; n = 0;
        for (int k = 2; k <= 256; k++) begin
            for (int i = 0; i < 6; i++) if (ed[i] == k) n++;
            if (n == 3) begin x = k; break; end
        end
        last = 0;
        for (int i = 0; i < 6; i++) if (ed[i] > last) last = ed[i];
        kmax = ((x > last) ? x : last) + 4;
        // C0: drive the start rise.
        start   = 1'b1;
        data_in = v.arm_hi;
        for (int k = 1; k <= kmax + LAT; k++) begin
            tick();
            if (k > LAT) begin
                int kk;
                kk = k - LAT;
                exp[10]  = (kk == 1);
                exp[9]   = (kk >= 2 && kk <= x);
                exp[8]   = (kk > x);
                exp[7:0] = (kk > x) ? 8'(x - 1) : 8'd0;
                chk(v.name, kk, {temp_reset, running, ready, count_out}, exp);
            end
            start   = v.hold || (k == v.run_start);
            data_in = v.arm_hi && (k <= 1);
            for (int i = 0; i < 6; i++) if (ed[i] == k) data_in = 1'b1;
        end
        start   = 1'b0;
        data_in = 1'b0;
        tick();
    endtask

    initial begin
        // The table is filled here and applied below.
        add(10, 20, 30,  0,  0,  0, 0,  0, 0, "basic");        // 29
        add(10, 20, 30, 40, 50, 60, 0,  0, 0, "extra_edges");  // 29, later edges ignored
        add( 5,  8, 12,  0,  0,  0, 0,  0, 0, "rearm");        // 11, armed from DONE
        add( 2,  4,  6,  0,  0,  0, 0,  0, 0, "first_run_cyc");// 5, edge in C2 counts
        add( 1,  3,  5,  7,  0,  0, 0,  0, 0, "arm_edge_ign"); // 6, edge in ARM ignored
        add(12, 20, 25,  0,  0,  0, 1, 15, 0, "ignored_in");   // 24
        add( 0,  0,  0,  0,  0,  0, 0,  0, 0, "overflow");     // 255
        add( 3,  9, 14,  0,  0,  0, 0,  0, 1, "start_held");   // 13, no retrigger

        // Reset state
        rst = 1'b1; start = 1'b0; data_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 0, {temp_reset, running, ready, count_out}, 11'd0);
        rst = 1'b0;
        tick();
        chk("post_reset_idle", 0, {temp_reset, running, ready, count_out}, 11'd0);

        // Reset asserted mid-RUN aborts at once, with no clock edge needed.
        start = 1'b1;
        tick(); start = 1'b0;
        repeat (6 + LAT) tick();
        chk("mid_run_pre", 0, {temp_reset, running, ready, count_out},
            {1'b0, 1'b1, 1'b0, 8'd0});
        #2 rst = 1'b1;
        #1 chk("async_reset", 0, {temp_reset, running, ready, count_out}, 11'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 24; k++) begin
            data_in = (k % 3 == 0);
            tick();
            chk("after_reset_idle", k, {temp_reset, running, ready, count_out}, 11'd0);
        end
        data_in = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
